// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 PIO definitions: FSM encoding, PIOC layout, register selects.
package jtdsp16_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned SWW = 2;

  // Strobe timing FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // PIOC bit positions
  localparam int unsigned PIOC_IBF    = 15;
  localparam int unsigned PIOC_OBE    = 14;
  localparam int unsigned PIOC_SW_MSB = 13;
  localparam int unsigned PIOC_SW_LSB = 12;
  localparam int unsigned PIOC_IE_IBF = 4;
  localparam int unsigned PIOC_IE_OBE = 3;

  // pio_sel codes
  localparam logic [1:0] SEL_PIOC = 2'b00;
  localparam logic [1:0] SEL_PDX0 = 2'b01;
  localparam logic [1:0] SEL_PDX1 = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam logic [DW-1:0] PIOC_RST = 16'h4000;

  // Stored PIOC fields; everything else reads as zero
  typedef struct packed {
    logic           ibf;
    logic           obe;
    logic [SWW-1:0] sw;
    logic           ie_ibf;
    logic           ie_obe;
  } pioc_t;

  // Place the stored fields at their architectural bit positions
  function automatic logic [DW-1:0] pioc_pack(input pioc_t p);
    logic [DW-1:0] v;
    v                          = '0;
    v[PIOC_IBF]                = p.ibf;
    v[PIOC_OBE]                = p.obe;
    v[PIOC_SW_MSB:PIOC_SW_LSB] = p.sw;
    v[PIOC_IE_IBF]             = p.ie_ibf;
    v[PIOC_IE_OBE]             = p.ie_obe;
    return v;
  endfunction

  // Extract the stored fields from a full 16-bit image
  function automatic pioc_t pioc_unpack(input logic [DW-1:0] v);
    pioc_t p;
    p.ibf    = v[PIOC_IBF];
    p.obe    = v[PIOC_OBE];
    p.sw     = v[PIOC_SW_MSB:PIOC_SW_LSB];
    p.ie_ibf = v[PIOC_IE_IBF];
    p.ie_obe = v[PIOC_IE_OBE];
    return p;
  endfunction

  function automatic logic is_pdx(input logic [1:0] sel);
    return (sel == SEL_PDX0) || (sel == SEL_PDX1);
  endfunction

endpackage

// File: rtl/jtdsp16_pio_strobe.sv
// SETUP/STROBE/HOLD timing engine for PDX bus transactions.
// One 2-bit counter is reused by every phase; the strobe width is captured
// from sw when SETUP ends, so the running strobe ignores later sw changes.
module jtdsp16_pio_strobe
  import jtdsp16_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen_i,
  input  logic           start_i,
  input  logic           start_rd_i,
  input  logic [SWW-1:0] sw_i,
  output logic           busy_o,
  output logic           strobe_active_o,
  output logic           rd_active_o,
  output logic           setup_done_c,
  output logic           last_strobe_c,
  output logic           done_c
);

  localparam logic [1:0] SETUP_LOAD = 2'(SETUP_CYC - 1);
  localparam logic [1:0] HOLD_LOAD  = 2'(HOLD_CYC - 1);

  logic [1:0]     state_q, state_d;
  logic [SWW-1:0] cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           busy_q, busy_d;
  logic           strobe_q, strobe_d;

  // Next-state, counter and phase-boundary pulses
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    setup_done_c  = 1'b0;
    last_strobe_c = 1'b0;
    done_c        = 1'b0;
    if (cen_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
            rd_d    = start_rd_i;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_d      = ST_STROBE;
            cnt_d        = sw_i;
            setup_done_c = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_d       = ST_HOLD;
            cnt_d         = rd_q ? 2'd0 : HOLD_LOAD;
            last_strobe_c = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_c  = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d   = (state_d != ST_IDLE);
    strobe_d = (state_d == ST_STROBE);
  end

  // State, counter and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
    end
  end

  assign busy_o          = busy_q;
  assign strobe_active_o = strobe_q;
  assign rd_active_o     = rd_q;

endmodule

// File: rtl/jtdsp16_pio.sv
// DSP16 parallel I/O unit: PIOC/PDX registers and strobed external bus.
// Define JTDSP16_PIO_IRQ_EN to enable the IBF/OBE interrupt and store
// PIOC[4:3]; otherwise irq is 0 and PIOC[4:3] read as 0.
module jtdsp16_pio
  import jtdsp16_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [1:0]    pio_sel,
  input  logic          we,
  input  logic          re,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] r_pio,
  output logic          busy,
  input  logic [DW-1:0] pbus_in,
  output logic [DW-1:0] pbus_out,
  output logic          pbus_oe,
  output logic          psel,
  output logic          pods_n,
  output logic          pids_n,
  output logic          irq
);

  pioc_t         pioc_q, pioc_d;
  logic [DW-1:0] pdx_out_q, pdx_out_d;
  logic [DW-1:0] pdx_in_q, pdx_in_d;
  logic          psel_q, psel_d;
  logic          pbus_oe_q, pbus_oe_d;
  logic          pods_n_q, pods_n_d;
  logic          pids_n_q, pids_n_d;
  logic          irq_q, irq_d;

  logic          busy_w;
  logic          strobe_active;
  logic          rd_active;
  logic          setup_done_c;
  logic          last_strobe_c;
  logic          done_c;

  logic          accept_c;
  logic          wr_pdx_c;
  logic          rd_pdx_c;
  logic          pioc_wr_c;
  logic          start_c;
  logic          strobe_next_c;

  // Request decode: only accepted while idle on a cen cycle; write beats read
  always_comb begin
    accept_c      = cen & ~busy_w;
    wr_pdx_c      = accept_c & we & is_pdx(pio_sel);
    rd_pdx_c      = accept_c & ~we & re & is_pdx(pio_sel);
    pioc_wr_c     = accept_c & we & (pio_sel == SEL_PIOC);
    start_c       = wr_pdx_c | rd_pdx_c;
    strobe_next_c = setup_done_c | (strobe_active & ~last_strobe_c);
  end

  jtdsp16_pio_strobe #(
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_strobe (
    .clk             (clk),
    .rst_n           (rst_n),
    .cen_i           (cen),
    .start_i         (start_c),
    .start_rd_i      (rd_pdx_c),
    .sw_i            (pioc_q.sw),
    .busy_o          (busy_w),
    .strobe_active_o (strobe_active),
    .rd_active_o     (rd_active),
    .setup_done_c    (setup_done_c),
    .last_strobe_c   (last_strobe_c),
    .done_c          (done_c)
  );

  // Register next-state: PIOC, PDX data, bus controls and interrupt
  always_comb begin
    pioc_d    = pioc_q;
    pdx_out_d = pdx_out_q;
    pdx_in_d  = pdx_in_q;
    psel_d    = psel_q;
    pbus_oe_d = pbus_oe_q;
    pods_n_d  = pods_n_q;
    pids_n_d  = pids_n_q;
    irq_d     = irq_q;
    if (cen) begin
      if (pioc_wr_c) begin
        pioc_d.sw = din[PIOC_SW_MSB:PIOC_SW_LSB];
`ifdef JTDSP16_PIO_IRQ_EN
        pioc_d.ie_ibf = din[PIOC_IE_IBF];
        pioc_d.ie_obe = din[PIOC_IE_OBE];
`endif
      end
      if (start_c) begin
        psel_d = pio_sel[1];
        if (wr_pdx_c) begin
          pdx_out_d  = din;
          pioc_d.obe = 1'b0;
          pbus_oe_d  = 1'b1;
        end else begin
          pioc_d.ibf = 1'b0;
        end
      end
      pods_n_d = ~(strobe_next_c & ~rd_active);
      pids_n_d = ~(strobe_next_c & rd_active);
      if (last_strobe_c && rd_active) begin
        pdx_in_d   = pbus_in;
        pioc_d.ibf = 1'b1;
      end
      if (done_c) begin
        pbus_oe_d = 1'b0;
        if (!rd_active) begin
          pioc_d.obe = 1'b1;
        end
      end
`ifdef JTDSP16_PIO_IRQ_EN
      irq_d = (pioc_q.ibf & pioc_q.ie_ibf) | (pioc_q.obe & pioc_q.ie_obe);
`else
      irq_d = 1'b0;
`endif
    end
  end

  // Register update with synchronous reset independent of cen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pioc_q    <= pioc_unpack(PIOC_RST);
      pdx_out_q <= '0;
      pdx_in_q  <= '0;
      psel_q    <= 1'b0;
      pbus_oe_q <= 1'b0;
      pods_n_q  <= 1'b1;
      pids_n_q  <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      pioc_q    <= pioc_d;
      pdx_out_q <= pdx_out_d;
      pdx_in_q  <= pdx_in_d;
      psel_q    <= psel_d;
      pbus_oe_q <= pbus_oe_d;
      pods_n_q  <= pods_n_d;
      pids_n_q  <= pids_n_d;
      irq_q     <= irq_d;
    end
  end

  // Read mux towards the register-read path
  always_comb begin
    r_pio = '0;
    case (pio_sel)
      SEL_PIOC: r_pio = pioc_pack(pioc_q);
      SEL_PDX0: r_pio = pdx_in_q;
      SEL_PDX1: r_pio = pdx_in_q;
      SEL_RSVD: r_pio = '0;
      default:  r_pio = '0;
    endcase
  end

  assign busy     = busy_w;
  assign pbus_out = pdx_out_q;
  assign pbus_oe  = pbus_oe_q;
  assign psel     = psel_q;
  assign pods_n   = pods_n_q;
  assign pids_n   = pids_n_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_jtdsp16_pio.sv
// Self-checking bench for jtdsp16_pio: transaction-level reference model,
// randomized data, selects, strobe widths, cen gaps and ignored requests.
module tb_jtdsp16_pio;

  localparam int unsigned S = 1;
  localparam int unsigned H = 1;

  logic        clk = 1'b0;
  logic        rst_n, cen, we, re;
  logic [1:0]  pio_sel;
  logic [15:0] din, pbus_in;
  logic [15:0] r_pio, pbus_out;
  logic        busy, pbus_oe, psel, pods_n, pids_n, irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (architectural view)
  logic        m_ibf, m_obe, m_ie_ibf, m_ie_obe;
  logic [1:0]  m_sw;
  logic [15:0] m_pdx_in, m_pdx_out;

  always #5 clk = ~clk;

  jtdsp16_pio #(.SETUP_CYC(S), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .pio_sel(pio_sel), .we(we), .re(re),
    .din(din), .r_pio(r_pio), .busy(busy), .pbus_in(pbus_in),
    .pbus_out(pbus_out), .pbus_oe(pbus_oe), .psel(psel), .pods_n(pods_n),
    .pids_n(pids_n), .irq(irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pioc_exp();
    logic [15:0] v;
    v = 16'h0000;
    v[15] = m_ibf; v[14] = m_obe; v[13:12] = m_sw;
    v[4] = m_ie_ibf; v[3] = m_ie_obe;
    return v;
  endfunction

  function automatic logic cause_exp();
    return (m_ibf & m_ie_ibf) | (m_obe & m_ie_obe);
  endfunction

  task automatic model_reset();
    m_ibf = 1'b0; m_obe = 1'b1; m_sw = 2'd0; m_ie_ibf = 1'b0; m_ie_obe = 1'b0;
    m_pdx_in = 16'h0; m_pdx_out = 16'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    we      = 1'($urandom_range(0, 1));
    re      = 1'($urandom_range(0, 1));
    pio_sel = 2'($urandom);
    din     = 16'($urandom);
  endtask

  task automatic pick_cen(input int mode, input int ek, inout int lows);
    if (mode == 1) cen = ($urandom_range(0, 3) != 0);
    else if (mode == 2 && ek == 1 && lows < 3) begin cen = 1'b0; lows++; end
    else cen = 1'b1;
  endtask

  task automatic do_pioc_write(input logic [15:0] data);
    we = 1'b1; re = 1'($urandom_range(0, 1)); pio_sel = 2'b00; din = data; cen = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    m_sw = data[13:12];
`ifdef JTDSP16_PIO_IRQ_EN
    m_ie_ibf = data[4]; m_ie_obe = data[3];
`endif
    #1;
    n_cmp++;
    if (r_pio !== pioc_exp()) begin
      n_bad++; $display("FAIL pioc_read got %h want %h", r_pio, pioc_exp());
    end
    n_cmp++;
    if ({busy, pbus_oe, pods_n, pids_n} !== 4'b0011) begin
      n_bad++; $display("FAIL pioc_no_bus got %b want 0011", {busy, pbus_oe, pods_n, pids_n});
    end
    step();
    n_cmp++;
    if (irq !== cause_exp()) begin
      n_bad++; $display("FAIL pioc_irq got %b want %b", irq, cause_exp());
    end
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [15:0] data,
                          input bit with_re, input int cen_mode);
    int total, ek, lows;
    bit done;
    logic obe_old, e_busy, e_pods, e_irq;
    logic [21:0] e_vec, a_vec;
    total = int'(S) + int'(m_sw) + 1 + int'(H);
    obe_old = m_obe;
    we = 1'b1; re = with_re; pio_sel = sel; din = data; cen = 1'b1;
    step();
    ek = 1; lows = 0; done = 1'b0;
    we = 1'b0; re = 1'b0; pio_sel = 2'b00;
    #1;
    n_cmp++;
    if (r_pio[14] !== 1'b0) begin
      n_bad++; $display("FAIL write_obe_clear got %b want 0", r_pio[14]);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      e_busy = (ek <= total);
      e_pods = !(ek >= int'(S) + 1 && ek <= int'(S) + int'(m_sw) + 1);
      e_irq  = (m_ibf & m_ie_ibf) | (m_ie_obe & ((ek == 1) ? obe_old : 1'b0));
      e_vec  = {e_busy, e_pods, 1'b1, e_busy, sel[1], data, e_irq};
      a_vec  = {busy, pods_n, pids_n, pbus_oe, psel, pbus_out, irq};
      n_cmp++;
      if (a_vec !== e_vec) begin
        n_bad++;
        $display("FAIL write_cycle ek=%0d {busy,pods_n,pids_n,oe,psel,out,irq} got %h want %h",
                 ek, a_vec, e_vec);
      end
      if (ek == total + 1) done = 1'b1;
      else begin
        pick_cen(cen_mode, ek, lows);
        drive_junk();
        pbus_in = 16'($urandom);
        step();
        if (cen) ek++;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++; $display("FAIL write_timeout ek=%0d want %0d", ek, total + 1);
    end
    we = 1'b0; re = 1'b0; cen = 1'b1; pio_sel = 2'b00;
    m_obe = 1'b1; m_pdx_out = data;
    #1;
    n_cmp++;
    if (r_pio !== pioc_exp()) begin
      n_bad++; $display("FAIL write_end_pioc got %h want %h", r_pio, pioc_exp());
    end
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [15:0] data, input int cen_mode);
    int total, last, ek, lows;
    bit done;
    logic ibf_old, e_busy, e_pids, e_irq;
    logic [21:0] e_vec, a_vec;
    total = int'(S) + int'(m_sw) + 2;
    last  = int'(S) + int'(m_sw) + 1;
    ibf_old = m_ibf;
    we = 1'b0; re = 1'b1; pio_sel = sel; cen = 1'b1; din = 16'($urandom);
    pbus_in = data ^ 16'($urandom_range(1, 65535));
    #1;
    n_cmp++;
    if (r_pio !== m_pdx_in) begin
      n_bad++; $display("FAIL read_request_data got %h want %h", r_pio, m_pdx_in);
    end
    step();
    ek = 1; lows = 0; done = 1'b0;
    re = 1'b0; pio_sel = 2'b00;
    #1;
    n_cmp++;
    if (r_pio[15] !== 1'b0) begin
      n_bad++; $display("FAIL read_ibf_clear got %b want 0", r_pio[15]);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      e_busy = (ek <= total);
      e_pids = !(ek >= int'(S) + 1 && ek <= last);
      e_irq  = (m_obe & m_ie_obe) | (m_ie_ibf & ((ek == 1) ? ibf_old : (ek - 1 >= last + 1)));
      e_vec  = {e_busy, 1'b1, e_pids, 1'b0, sel[1], m_pdx_out, e_irq};
      a_vec  = {busy, pods_n, pids_n, pbus_oe, psel, pbus_out, irq};
      n_cmp++;
      if (a_vec !== e_vec) begin
        n_bad++;
        $display("FAIL read_cycle ek=%0d {busy,pods_n,pids_n,oe,psel,out,irq} got %h want %h",
                 ek, a_vec, e_vec);
      end
      if (ek == total + 1) done = 1'b1;
      else begin
        pick_cen(cen_mode, ek, lows);
        drive_junk();
        pbus_in = (cen && ek == last) ? data : (data ^ 16'($urandom_range(1, 65535)));
        step();
        if (cen) ek++;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++; $display("FAIL read_timeout ek=%0d want %0d", ek, total + 1);
    end
    we = 1'b0; re = 1'b0; cen = 1'b1;
    m_pdx_in = data; m_ibf = 1'b1;
    pio_sel = 2'b00; #1;
    n_cmp++;
    if (r_pio !== pioc_exp()) begin
      n_bad++; $display("FAIL read_end_pioc got %h want %h", r_pio, pioc_exp());
    end
    pio_sel = sel; #1;
    n_cmp++;
    if (r_pio !== data) begin
      n_bad++; $display("FAIL read_end_pdx got %h want %h", r_pio, data);
    end
    pio_sel = 2'b11; #1;
    n_cmp++;
    if (r_pio !== 16'h0000) begin
      n_bad++; $display("FAIL read_rsvd got %h want 0000", r_pio);
    end
    pio_sel = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; we = 1'b0; re = 1'b0; pio_sel = 2'b00; din = 16'h0; pbus_in = 16'h0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    model_reset();
    n_cmp++;
    if (r_pio !== 16'h4000) begin
      n_bad++; $display("FAIL reset_pioc got %h want 4000", r_pio);
    end
    n_cmp++;
    if ({pods_n, pids_n, pbus_oe, busy, irq, psel, pbus_out} !== {6'b110000, 16'h0000}) begin
      n_bad++; $display("FAIL reset_outputs got %h want %h",
                        {pods_n, pids_n, pbus_oe, busy, irq, psel, pbus_out}, {6'b110000, 16'h0000});
    end
    cen = 1'b1;
  endtask

  task automatic test_pioc();
    do_pioc_write(16'hFFFF);
    pio_sel = 2'b00; #1;
    n_cmp++;
`ifdef JTDSP16_PIO_IRQ_EN
    if (r_pio !== 16'h7018) begin n_bad++; $display("FAIL pioc_ffff got %h want 7018", r_pio); end
`else
    if (r_pio !== 16'h7000) begin n_bad++; $display("FAIL pioc_ffff got %h want 7000", r_pio); end
`endif
  endtask

  task automatic test_pdx1_write();
    do_pioc_write(16'h3000);
    do_write(2'b10, 16'hA5C3, 1'b0, 0);
  endtask

  task automatic test_pdx0_read();
    do_pioc_write(16'h0000);
    do_read(2'b01, 16'h1234, 0);
    do_read(2'b01, 16'hBEEF, 0);
  endtask

  task automatic test_back_to_back();
    do_write(2'b01, 16'h00FF, 1'b1, 0);
    do_write(2'b10, 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_reserved();
    logic [15:0] junk;
    junk = 16'($urandom);
    we = 1'b1; re = 1'b0; pio_sel = 2'b11; din = junk; cen = 1'b1;
    step();
    we = 1'b0; re = 1'b1; #1;
    n_cmp++;
    if (r_pio !== 16'h0000) begin n_bad++; $display("FAIL rsvd_read got %h want 0000", r_pio); end
    step();
    re = 1'b0;
    n_cmp++;
    if ({busy, pbus_oe, pods_n, pids_n, pbus_out} !== {4'b0011, m_pdx_out}) begin
      n_bad++; $display("FAIL rsvd_ignored got %h want %h",
                        {busy, pbus_oe, pods_n, pids_n, pbus_out}, {4'b0011, m_pdx_out});
    end
    pio_sel = 2'b00; #1;
    n_cmp++;
    if (r_pio !== pioc_exp()) begin n_bad++; $display("FAIL rsvd_pioc got %h want %h", r_pio, pioc_exp()); end
  endtask

  task automatic test_cen_stretch();
    do_pioc_write(16'h1000);
    do_write(2'b01, 16'($urandom), 1'b0, 2);
    do_read(2'b10, 16'($urandom), 2);
    do_write(2'b10, 16'($urandom), 1'b1, 1);
    do_read(2'b01, 16'($urandom), 1);
  endtask

  task automatic test_irq();
    do_pioc_write(16'h0010);
    do_read(2'b01, 16'($urandom), 0);
    do_read(2'b10, 16'($urandom), 1);
    do_pioc_write(16'h0008);
    do_write(2'b01, 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    do_pioc_write(16'h2000);
    we = 1'b1; re = 1'b0; pio_sel = 2'b01; din = 16'($urandom) | 16'h0001; cen = 1'b1;
    step();
    we = 1'b0;
    repeat (S) step();
    n_cmp++;
    if (pods_n !== 1'b0) begin n_bad++; $display("FAIL midrst_in_strobe got %b want 0", pods_n); end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({pods_n, pids_n, pbus_oe, busy, irq, pbus_out} !== {5'b11000, 16'h0000}) begin
      n_bad++; $display("FAIL midrst_outputs got %h want %h",
                        {pods_n, pids_n, pbus_oe, busy, irq, pbus_out}, {5'b11000, 16'h0000});
    end
    pio_sel = 2'b00; #1;
    n_cmp++;
    if (r_pio !== 16'h4000) begin n_bad++; $display("FAIL midrst_pioc got %h want 4000", r_pio); end
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: do_pioc_write(16'($urandom));
        1: do_write(2'($urandom_range(1, 2)), 16'($urandom), 1'b0, 1);
        2: do_read(2'($urandom_range(1, 2)), 16'($urandom), 1);
        default: do_write(2'($urandom_range(1, 2)), 16'($urandom), 1'b1, 0);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_pioc();
    test_pdx1_write();
    test_pdx0_read();
    test_back_to_back();
    test_reserved();
    test_cen_stretch();
    test_irq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtdsp16_pio.md
Name: jtdsp16_pio

Overview:
- Parallel I/O unit of the DSP16 core; sits directly upstream of the register-read mux and supplies its r_pio input (the mux source for rsel = 3'b111).
- Holds the PIOC control/status register and the PDX input/output data registers.
- Generates the external strobed parallel-bus transactions (PODS/PIDS, PSEL) for PDX0/PDX1 accesses.

Parameters:
SETUP_CYC, 1, cen cycles between PSEL/data valid and the strobe falling (1..3)
HOLD_CYC, 1, cen cycles output data stays driven after the strobe rises (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cen  in  1  clock enable; every state change is qualified by cen
pio_sel  in  2  register select: 00 PIOC, 01 PDX0, 10 PDX1, 11 reserved
we  in  1  write request
re  in  1  read request
din  in  16  write data from the internal bus
r_pio  out  16  read data to the register-read mux
busy  out  1  transaction in progress; core must stall PDX accesses
pbus_in  in  16  external parallel bus input
pbus_out  out  16  external parallel bus output
pbus_oe  out  1  output enable for pbus_out
psel  out  1  0 = PDX0, 1 = PDX1
pods_n  out  1  output data strobe, active low
pids_n  out  1  input data strobe, active low
irq  out  1  PIO interrupt request

Behaviour:
- Reset is synchronous, active low on clk, and independent of cen. Reset values:
  - PIOC = 16'h4000; pdx_out = 0; pdx_in = 0.
  - pbus_out = 0, pbus_oe = 0, psel = 0, pods_n = 1, pids_n = 1, busy = 0, irq = 0.
- A reset mid-transaction aborts it. Strobes deassert at the same edge, and the latched data is discarded.
- PIOC layout:
  - [15] IBF, read-only.
  - [14] OBE, read-only.
  - [13:12] sw (strobe width).
  - [4] ie_ibf; [3] ie_obe.
  - All other bits read 0. A PIOC write stores only bits 13:12 and 4:3, with no bus activity.
- r_pio is combinational on pio_sel: PIOC, pdx_in (for both 01 and 10), or 0 for code 11.
- FSM states: IDLE, SETUP, STROBE, HOLD. busy = (state != IDLE), registered.
- Requests are accepted only in IDLE with cen = 1. Requests while busy are ignored.
- we and re together: the write wins and the read is dropped. Reserved select code 11: write ignored, reads return 0.
- Output transaction (we with PDX sel, at edge t):
  - Edge t: pdx_out <= din; OBE <= 0; psel <= sel[1]; pbus_out <= din; pbus_oe <= 1; go to SETUP.
  - SETUP lasts SETUP_CYC cen cycles.
  - STROBE: pods_n = 0 for sw+1 cen cycles.
  - HOLD: pods_n = 1, pbus_oe still 1, for HOLD_CYC cycles.
  - Then IDLE: pbus_oe <= 0, OBE <= 1.
- Input transaction (re with PDX sel):
  - r_pio presents the current pdx_in in the request cycle.
  - IBF <= 0; psel set; pbus_oe stays 0; go to SETUP.
  - STROBE: pids_n = 0 for sw+1 cycles. pbus_in is sampled into pdx_in on the last STROBE cen edge, and IBF <= 1 on that same edge.
  - HOLD: 1 cycle with pids_n = 1, then IDLE.
- Strobe counter: 2 bits, loaded with sw at SETUP exit, decrements to 0. A PIOC.sw change mid-transaction does not affect the running strobe.
- cen = 0 freezes the FSM, counters and registers; outputs hold their values.
- Total output transaction length = SETUP_CYC + sw + 1 + HOLD_CYC cen cycles.

Optional Feature:
JTDSP16_PIO_IRQ_EN
- Defined:
  - irq is registered: irq <= (IBF & ie_ibf) | (OBE & ie_obe), updated on cen.
  - irq clears when the causing flag clears (IBF by a PDX read; OBE by a PDX write).
- Undefined:
  - irq tied 0.
  - PIOC bits 4:3 are not stored and read 0.

Decomposition:
- Shared package jtdsp16_pkg holds:
  - FSM state encoding.
  - PIOC bit-position constants (IBF, OBE, SW_MSB/LSB, IE_IBF, IE_OBE).
  - pio_sel codes.
  - PIOC reset value 16'h4000.
- One sub-module, jtdsp16_pio_strobe: the SETUP/STROBE/HOLD timing FSM and counters, driving a strobe_active signal and a last_strobe pulse. The parent owns the registers and the bus muxing.

Test Plan:
- Reset: after rst_n low for 2 clk then high, r_pio with sel 00 = 16'h4000; pods_n = pids_n = 1; pbus_oe = 0; busy = 0.
- PIOC write, then PDX1 write:
  - Stimulus: write PIOC = 16'hFFFF, then read PIOC; with cen = 1, write PDX1 = 16'hA5C3 (sw = 3, SETUP_CYC = HOLD_CYC = 1).
  - PIOC read = 16'h7018 (IRQ_EN) or 16'h7000 (no IRQ_EN).
  - PDX1 write: psel = 1 and pbus_out = A5C3 for 6 cycles; pods_n low exactly cycles 2-5; OBE = 1 and busy = 0 at cycle 6.
- PDX0 read, sw = 0, pbus_in = 16'h1234:
  - pids_n low for exactly 1 cycle; IBF = 1 afterwards.
  - A next PDX0 read returns 16'h1234 and IBF drops.
- Simultaneous we & re with PDX0 sel, din = 16'h00FF: output transaction only, pids_n never falls. A second write issued while busy = 1 is ignored (pbus_out stays 16'h00FF).
- Reset during STROBE of a write: pods_n = 1, pbus_oe = 0 and PIOC = 16'h4000 on the next edge; cen held low mid-SETUP stretches the transaction by exactly the number of low cycles.
- IRQ (with JTDSP16_PIO_IRQ_EN): set ie_ibf, complete a PDX read → irq = 1 one cycle after IBF rises; a second PDX read → irq = 0 one cycle after IBF clears.
